// File: rtl/data_mem_responder.sv
// Word-addressed data memory that answers one load/store request at a time after
// a fixed number of wait cycles, flagging misaligned and out-of-range addresses.
module data_mem_responder #(
    parameter int N_BITS     = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int LATENCY    = 2
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              MemReq,
    input  logic              MemWrite,
    input  logic [N_BITS-1:0] Addr,
    input  logic [N_BITS-1:0] WriteData,
    output logic [N_BITS-1:0] ReadData,
    output logic              MemReady,
    output logic              MemErr,
    output logic              Busy
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t                  state_q;
    logic [3:0]              cnt_q;
    logic [ADDR_WIDTH-1:0]   idx_q;
    logic [N_BITS-1:0]       wdata_q;
    logic                    we_q;
    logic                    err_q;
    logic [N_BITS-1:0]       rdata_q;
    logic                    ready_q;
    logic                    merr_q;
    logic [N_BITS-1:0]       mem_q [DEPTH];

    logic                    req_err;
    logic                    enter_resp;
    logic [ADDR_WIDTH-1:0]   eff_idx;
    logic [N_BITS-1:0]       eff_wdata;
    logic                    eff_we;
    logic                    eff_err;
    logic                    mem_wr;

    // Any byte offset or any address bit above the word index is an error.
    assign req_err = (Addr[1:0] != 2'b00) || ((Addr >> (ADDR_WIDTH + 2)) != '0);

    // A zero-latency request enters RESP on its acceptance edge, so the live
    // inputs must be used instead of the (not yet loaded) request registers.
    always_comb begin
        enter_resp = 1'b0;
        eff_idx    = idx_q;
        eff_wdata  = wdata_q;
        eff_we     = we_q;
        eff_err    = err_q;
        case (state_q)
            S_IDLE: begin
                if (MemReq && (LATENCY == 0)) begin
                    enter_resp = 1'b1;
                    eff_idx    = Addr[ADDR_WIDTH+1:2];
                    eff_wdata  = WriteData;
                    eff_we     = MemWrite;
                    eff_err    = req_err;
                end
            end
            S_WAIT:  enter_resp = (cnt_q == 4'd0);
            default: enter_resp = 1'b0;
        endcase
    end

    assign mem_wr = enter_resp && eff_we && !eff_err;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_wr) begin
            mem_q[eff_idx] <= eff_wdata;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            merr_q  <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            merr_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (MemReq) begin
                        idx_q   <= Addr[ADDR_WIDTH+1:2];
                        wdata_q <= WriteData;
                        we_q    <= MemWrite;
                        err_q   <= req_err;
                        if (LATENCY == 0) begin
                            state_q <= S_RESP;
                        end else begin
                            cnt_q   <= CNT_INIT;
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            // Response side effects happen on the RESP entry edge; a write
            // leaves ReadData untouched.
            if (enter_resp) begin
                ready_q <= 1'b1;
                merr_q  <= eff_err;
                if (eff_err) begin
                    rdata_q <= '0;
                end else if (!eff_we) begin
                    rdata_q <= mem_q[eff_idx];
                end
            end
        end
    end

    assign ReadData = rdata_q;
    assign MemReady = ready_q;
    assign MemErr   = merr_q;
    assign Busy     = (state_q != S_IDLE);

endmodule
